ysyx_23060042_lsu: RTL and testbench
====================================

Name: ysyx_23060042_lsu

Overview:
Load/store unit directly downstream of the execute stage in the multi-cycle NPC core. It takes the ALU result as the effective address (or as a pass-through writeback value) plus the rs2 store data. It runs a single outstanding request on a req/gnt/rvalid memory port and returns size-extracted, sign- or zero-extended load data to writeback. It uses valid/ready handshakes on both the EXU side and the WBU side.

Parameters:
AW, 32, address width
DW, 32, data width; fixed at 32, with 4 byte lanes

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset (0 = reset)
in_valid  in  1  EXU presents an op
in_ready  out  1  LSU accepts an op
in_addr  in  AW  ALU result: effective address or pass-through value
in_wdata  in  DW  store data (rs2)
in_ren  in  1  load op
in_wen  in  1  store op; in_ren and in_wen both 1 is illegal
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_rd  in  5  destination register index
out_valid  out  1  result ready for WBU
out_ready  in  1  WBU accepts
out_data  out  DW  extracted load data or pass-through value
out_rd  out  5  latched rd
out_rf_wen  out  1  register write enable: 1 for load/pass-through, 0 for store or error
out_err  out  1  misaligned/illegal access flag
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  AW  word-aligned address, {addr[AW-1:2],2'b00}
mem_wdata  out  DW  lane-shifted store data
mem_wmask  out  4  byte-lane write mask
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid / write ack
mem_rdata  in  DW  read word

Behaviour:
- Reset (rst=0 at posedge): state←IDLE; all latched regs←0. While rst=0 all outputs read 0, including in_ready=0.
- States: IDLE, REQ, WAIT, DONE. Only one op in flight.
- IDLE: in_ready=1. On in_valid&in_ready, latch addr, wdata, ren, wen, funct3, rd.
  - Neither ren nor wen: go to DONE with out_data=in_addr, out_rf_wen=1. No memory access; result appears 1 cycle after accept.
  - Illegal or misaligned access: go to DONE with out_err=1, out_rf_wen=0, no mem_req. Illegal means funct3 outside the legal set, a store with funct3 in {100,101}, or ren&wen. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise go to REQ.
- REQ: mem_req=1; mem_we/addr/wdata/wmask are stable until gnt.
  - gnt=1 and rvalid=1 in the same cycle: go to DONE (capture rdata).
  - gnt=1 only: go to WAIT.
  - gnt=0: hold REQ indefinitely.
- WAIT: mem_req=0. On rvalid go to DONE and capture rdata; stores treat rvalid as a write ack and ignore rdata. Otherwise hold.
- DONE: out_valid=1 and outputs stable. On out_ready go to IDLE. in_ready=0, so there is no accept in the same cycle and max throughput is one op per 2+ cycles.
- Write lanes, with off=addr[1:0]:
  - SB: wmask=4'b0001<<off; wdata={4{wdata[7:0]}}.
  - SH: wmask=4'b0011<<off; wdata={2{wdata[15:0]}}.
  - SW: wmask=4'b1111; wdata as-is.
  - For loads, mem_we=0 and wmask=0.
- Load extraction: byte=rdata[8*off+:8] and half=rdata[16*off[1]+:16]. B/H sign-extend, BU/HU zero-extend, W passes the word through.
- rvalid or gnt arriving outside the REQ/WAIT states is ignored.
- Reset mid-operation in any state: back to IDLE the next cycle. mem_req drops and any later rvalid is ignored. No output is produced for the dropped op.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, mem_req=0, out_valid=0. After release, in_ready=1.
- Pass-through: addr=0x1234_5678, ren=wen=0, rd=5 → out_valid 1 cycle after accept with out_data=0x12345678, out_rd=5, out_rf_wen=1, mem_req never asserted.
- LB sign: addr=0x8000_0003, funct3=000, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x80AB_CDEF → mem_addr=0x80000000, out_data=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH lane: addr=0x8000_0102, funct3=001, wdata=0xDEAD_BEEF, gnt=rvalid=1 in the same cycle → mem_wmask=4'b1100, mem_wdata=0xBEEF_BEEF, out_rf_wen=0, out_err=0.
- Misaligned: LW at addr=0x8000_0006 → no mem_req, out_err=1, out_rf_wen=0. LH at 0x8000_0001 → same.
- Backpressure/reset: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Separately, pull rst=0 during WAIT, then pulse rvalid → no out_valid and state is IDLE.

Source files
------------

// File: rtl/ysyx_23060042_lsu_if.sv
// LSU port bundle: EXU-side op handshake, WBU-side result handshake and the req/gnt/rvalid memory port.
// The slave modport is the LSU view; master is the surrounding core (or a bench).
interface ysyx_23060042_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          in_ren;
    logic          in_wen;
    logic [2:0]    in_funct3;
    logic [4:0]    in_rd;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [4:0]    out_rd;
    logic          out_rf_wen;
    logic          out_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3, in_rd,
        input  out_ready, mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, out_valid, out_data, out_rd, out_rf_wen, out_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3, in_rd,
        output out_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, out_valid, out_data, out_rd, out_rf_wen, out_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_23060042_lsu.sv
// Single-outstanding load/store unit between EXU and WBU; lane-shifts stores and
// size/sign-extracts loads on a word-wide req/gnt/rvalid memory port.
//
// state | meaning
// IDLE  | ready for an op from EXU
// REQ   | mem_req held with stable address/data until gnt
// WAIT  | granted, waiting for rvalid (read data or write ack)
// DONE  | result presented to WBU until out_ready
module ysyx_23060042_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic                clk,
    input logic                rst,
    ysyx_23060042_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          ren_q, wen_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] data_q;
    logic          rf_wen_q, err_q;

    logic          is_mem, f3_legal, illegal, misalign, bad, accept, capture;
    logic [1:0]    off;
    logic [7:0]    lb;
    logic [15:0]   lh;
    logic [DW-1:0] ld, wlane;
    logic [3:0]    wmask;

    assign is_mem   = bus.in_ren | bus.in_wen;
    assign f3_legal = (bus.in_funct3 != 3'b011) && (bus.in_funct3[2:1] != 2'b11);
    assign illegal  = (bus.in_ren && bus.in_wen) || !f3_legal || (bus.in_wen && bus.in_funct3[2]);
    assign misalign = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                      ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
    assign bad      = illegal || misalign;
    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign capture  = ((state_q == REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                      ((state_q == WAIT) && bus.mem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = (!is_mem || bad) ? DONE : REQ;
            REQ:  if (bus.mem_gnt) state_d = bus.mem_rvalid ? DONE : WAIT;
            WAIT: if (bus.mem_rvalid) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stores and faulted ops leave out_data at zero; only loads and pass-through write it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            rf_wen_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= bus.in_addr;
            wdata_q  <= bus.in_wdata;
            ren_q    <= bus.in_ren;
            wen_q    <= bus.in_wen;
            funct3_q <= bus.in_funct3;
            rd_q     <= bus.in_rd;
            data_q   <= is_mem ? '0 : bus.in_addr;
            rf_wen_q <= !is_mem || (bus.in_ren && !bad);
            err_q    <= is_mem && bad;
        end else if (capture && ren_q) begin
            data_q   <= ld;
        end
    end

    assign off = addr_q[1:0];
    assign lb  = bus.mem_rdata[{off, 3'b000} +: 8];
    assign lh  = bus.mem_rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  ld = {{24{lb[7]}}, lb};
            3'b100:  ld = {24'b0, lb};
            3'b001:  ld = {{16{lh[15]}}, lh};
            3'b101:  ld = {16'b0, lh};
            default: ld = bus.mem_rdata;
        endcase
    end

    always_comb begin
        wmask = 4'b1111;
        wlane = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                wmask = 4'b0001 << off;
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask = 4'b0011 << off;
                wlane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Everything reads zero while reset is held, independent of the registered state.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_rd     = '0;
        bus.out_rf_wen = 1'b0;
        bus.out_err    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wmask  = '0;
        if (rst) begin
            bus.in_ready   = (state_q == IDLE);
            bus.out_valid  = (state_q == DONE);
            bus.out_data   = data_q;
            bus.out_rd     = rd_q;
            bus.out_rf_wen = rf_wen_q;
            bus.out_err    = err_q;
            if (state_q == REQ) begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = wen_q;
                bus.mem_addr  = {addr_q[AW-1:2], 2'b00};
                bus.mem_wdata = wen_q ? wlane : '0;
                bus.mem_wmask = wen_q ? wmask : 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// Scoreboard bench for the LSU: expected WBU results are queued at issue and popped when out_valid shows.
module tb_ysyx_23060042_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ysyx_23060042_lsu_if bus();
    ysyx_23060042_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rf_wen;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] addr, input logic [31:0] wdata, input logic ren,
                         input logic wen, input logic [2:0] f3, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input int hold);
        exp_t        e;
        exp_t        got;
        logic        bad;
        logic        is_mem;
        logic [31:0] sh;
        logic [3:0]  em;
        logic [31:0] ew;
        logic [31:0] held;
        int          n;

        is_mem = ren | wen;
        bad = (ren && wen) || (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wen && f3[2]) ||
              ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        sh = rdata >> {addr[1:0], 3'b000};
        e.rd = rd;
        if (!is_mem) begin
            e.data = addr; e.rf_wen = 1'b1; e.err = 1'b0;
        end else if (bad) begin
            e.data = '0; e.rf_wen = 1'b0; e.err = 1'b1;
        end else if (wen) begin
            e.data = '0; e.rf_wen = 1'b0; e.err = 1'b0;
        end else begin
            e.rf_wen = 1'b1; e.err = 1'b0;
            case (f3)
                3'b000:  e.data = {{24{sh[7]}}, sh[7:0]};
                3'b100:  e.data = {24'b0, sh[7:0]};
                3'b001:  e.data = {{16{sh[15]}}, sh[15:0]};
                3'b101:  e.data = {16'b0, sh[15:0]};
                default: e.data = rdata;
            endcase
        end
        case (f3[1:0])
            2'b00:   begin em = 4'b0001 << addr[1:0]; ew = {4{wdata[7:0]}}; end
            2'b01:   begin em = 4'b0011 << addr[1:0]; ew = {2{wdata[15:0]}}; end
            default: begin em = 4'b1111; ew = wdata; end
        endcase
        sb.push_back(e);

        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_addr = addr; bus.in_wdata = wdata;
        bus.in_ren = ren; bus.in_wen = wen; bus.in_funct3 = f3; bus.in_rd = rd;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_ren = 1'b0; bus.in_wen = 1'b0;
        bus.in_addr = 32'hA5A5_A5A5; bus.in_rd = 5'd0;

        if (is_mem && !bad) begin
            for (int i = 0; i < gnt_dly; i++) begin
                check("req_held", 32'(bus.mem_req), 32'd1);
                check("addr_held", bus.mem_addr, {addr[31:2], 2'b00});
                @(negedge clk);
            end
            check("mem_req", 32'(bus.mem_req), 32'd1);
            check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            check("mem_we", 32'(bus.mem_we), 32'(wen));
            check("mem_wmask", 32'(bus.mem_wmask), wen ? 32'(em) : 32'd0);
            if (wen) check("mem_wdata", bus.mem_wdata, ew);
            bus.mem_gnt = 1'b1;
            bus.mem_rvalid = (rv_dly == 0);
            bus.mem_rdata = rdata;
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = ~rdata;
            if (rv_dly > 0) begin
                for (int i = 1; i < rv_dly; i++) begin
                    check("wait_no_req", 32'(bus.mem_req), 32'd0);
                    check("wait_no_valid", 32'(bus.out_valid), 32'd0);
                    @(negedge clk);
                end
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
                @(negedge clk);
                bus.mem_rvalid = 1'b0; bus.mem_rdata = ~rdata;
            end
        end else begin
            check("no_mem_req", 32'(bus.mem_req), 32'd0);
        end

        check("out_valid", 32'(bus.out_valid), 32'd1);
        if (bus.out_valid && sb.size() > 0) begin
            got = sb.pop_front();
            check("out_data", bus.out_data, got.data);
            check("out_rd", 32'(bus.out_rd), 32'(got.rd));
            check("out_rf_wen", 32'(bus.out_rf_wen), 32'(got.rf_wen));
            check("out_err", 32'(bus.out_err), 32'(got.err));
            held = bus.out_data;
            for (int i = 0; i < hold; i++) begin
                bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
                @(negedge clk);
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
                check("bp_valid", 32'(bus.out_valid), 32'd1);
                check("bp_data", bus.out_data, held);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_mem_req", 32'(bus.mem_req), 32'd0);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drained_valid", 32'(bus.out_valid), 32'd0);
        check("drained_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_ren = 1'b0;
        bus.in_wen = 1'b0; bus.in_funct3 = '0; bus.in_rd = '0; bus.out_ready = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // reset held with an op offered
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_mem_req", 32'(bus.mem_req), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        //     addr          wdata         ren   wen   f3      rd  gnt rv  rdata        hold
        do_op(32'h1234_5678, 32'h0,        1'b0, 1'b0, 3'b000, 5,  0,  0, 32'h0,        0);
        do_op(32'h8000_0003, 32'h0,        1'b1, 1'b0, 3'b000, 6,  2,  3, 32'h80AB_CDEF, 5);
        do_op(32'h8000_0003, 32'h0,        1'b1, 1'b0, 3'b100, 7,  2,  3, 32'h80AB_CDEF, 0);
        do_op(32'h8000_0102, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001, 8,  0,  0, 32'h0,        0);
        do_op(32'h8000_0006, 32'h0,        1'b1, 1'b0, 3'b010, 9,  0,  0, 32'h0,        0);
        do_op(32'h8000_0001, 32'h0,        1'b1, 1'b0, 3'b001, 10, 0,  0, 32'h0,        0);
        do_op(32'h8000_0002, 32'h0,        1'b1, 1'b0, 3'b001, 11, 1,  1, 32'h9234_5678, 0);
        do_op(32'h8000_0000, 32'h0,        1'b1, 1'b0, 3'b101, 12, 0,  2, 32'h1234_8765, 0);
        do_op(32'h8000_0008, 32'h0,        1'b1, 1'b0, 3'b010, 13, 3,  0, 32'hCAFE_F00D, 0);
        do_op(32'h8000_0021, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 14, 0,  1, 32'h0,        0);
        do_op(32'h8000_0010, 32'h0123_4567, 1'b0, 1'b1, 3'b010, 15, 1,  2, 32'hFFFF_FFFF, 0);
        do_op(32'h8000_0001, 32'h0,        1'b1, 1'b0, 3'b000, 16, 0,  1, 32'h0000_7F00, 0);
        do_op(32'h8000_0040, 32'h0,        1'b1, 1'b0, 3'b011, 17, 0,  0, 32'h0,        0);
        do_op(32'h8000_0040, 32'h0,        1'b0, 1'b1, 3'b100, 18, 0,  0, 32'h0,        0);
        do_op(32'h8000_0040, 32'h0,        1'b1, 1'b1, 3'b010, 19, 0,  0, 32'h0,        0);
        do_op(32'hFFFF_0001, 32'h0,        1'b0, 1'b0, 3'b111, 20, 0,  0, 32'h0,        0);

        // reset while waiting for rvalid drops the op
        bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0010; bus.in_ren = 1'b1;
        bus.in_funct3 = 3'b010; bus.in_rd = 5'd21;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_ren = 1'b0;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("wait_state_req", 32'(bus.mem_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_idle", 32'(bus.in_ready), 32'd1);
        check("midrst_no_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        check("midrst_still_quiet", 32'(bus.out_valid), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
